// File: rtl/ks_wide_add_seq_if.sv
// ks_wide_add_seq_if: bundles the operand handshake, the result handshake
// and the chunk-wide link to the registered Kogge-Stone adder.
// The slave modport is the sequencer's view of these signals. The master
// modport is the environment's view: the operand producer, the result
// consumer and the adder.
// Optional macro KS_WIDE_SEQ_OVF_EN adds the out_ovf result flag.
interface ks_wide_add_seq_if #(
  parameter int CHUNK_W = 32,
  parameter int NCHUNK  = 4
);
  localparam int W = CHUNK_W * NCHUNK;

  // operand handshake
  logic               in_valid;
  logic               in_ready;
  logic [W-1:0]       in_a;
  logic [W-1:0]       in_b;
  logic               in_cin;

  // result handshake
  logic               out_valid;
  logic               out_ready;
  logic [W-1:0]       out_sum;
  logic               out_cout;
`ifdef KS_WIDE_SEQ_OVF_EN
  logic               out_ovf;
`endif

  // link to the registered chunk adder
  logic [CHUNK_W-1:0] add_a;
  logic [CHUNK_W-1:0] add_b;
  logic               add_cin;
  logic [CHUNK_W-1:0] add_sum;
  logic               add_cout;

`ifdef KS_WIDE_SEQ_OVF_EN
  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready, add_sum, add_cout,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, add_a, add_b, add_cin
  );
  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready, add_sum, add_cout,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, add_a, add_b, add_cin
  );
`else
  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready, add_sum, add_cout,
    input  in_ready, out_valid, out_sum, out_cout, add_a, add_b, add_cin
  );
  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready, add_sum, add_cout,
    output in_ready, out_valid, out_sum, out_cout, add_a, add_b, add_cin
  );
`endif

endinterface

// File: rtl/ks_wide_add_seq.sv
// ks_wide_add_seq: feeds a W-bit operand pair, one CHUNK_W slice per cycle
// (LSB slice first), into an external registered adder that has one cycle of
// latency. The adder's registered carry is chained back into its carry-in,
// and the W-bit sum plus the final carry-out are reassembled for a
// valid/ready consumer.
// Optional macro KS_WIDE_SEQ_OVF_EN adds out_ovf, the two's-complement
// signed overflow of the full W-bit add.
module ks_wide_add_seq #(
  parameter int CHUNK_W = 32,
  parameter int NCHUNK  = 4
) (
  input logic              clk,
  input logic              resetn,
  ks_wide_add_seq_if.slave bus
);

  localparam int W    = CHUNK_W * NCHUNK;
  localparam int IDXW = $clog2(NCHUNK);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    CAP,
    DONE
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [IDXW-1:0]    idx;

  logic [W-1:0]       op_a;
  logic [W-1:0]       op_b;
  logic               op_cin;

  logic [W-1:0]       sum_q;
  logic               cout_q;
`ifdef KS_WIDE_SEQ_OVF_EN
  logic               ovf_q;
`endif

  logic               in_ready_c;
  logic               out_valid_c;
  logic [CHUNK_W-1:0] add_a_c;
  logic [CHUNK_W-1:0] add_b_c;
  logic               add_cin_c;

  // State register; reset drops any operation in flight back to IDLE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, handshake outputs and adder drive. The adder is held at zero
  // outside RUN. In RUN, slice 0 takes the latched carry-in and every later
  // slice takes the previous slice's registered carry straight from the adder.
  always_comb begin
    state_nxt   = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    add_a_c     = '0;
    add_b_c     = '0;
    add_cin_c   = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        for (int c = 0; c < NCHUNK; c++) begin
          if (idx == IDXW'(c)) begin
            add_a_c = op_a[c*CHUNK_W +: CHUNK_W];
            add_b_c = op_b[c*CHUNK_W +: CHUNK_W];
          end
        end
        add_cin_c = (idx == '0) ? op_cin : bus.add_cout;
        if (idx == LAST_IDX) begin
          state_nxt = CAP;
        end
      end
      CAP: begin
        state_nxt = DONE;
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand latch, slice counter and result assembly. A returning sum always
  // belongs to the slice issued one cycle earlier, so slice idx-1 is written
  // during RUN and the top slice plus the carry-out are written in CAP.
  // Operands are sampled only in IDLE, so in_valid in any other state has
  // no effect.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idx    <= '0;
      op_a   <= '0;
      op_b   <= '0;
      op_cin <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
`ifdef KS_WIDE_SEQ_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            op_a   <= bus.in_a;
            op_b   <= bus.in_b;
            op_cin <= bus.in_cin;
            idx    <= '0;
          end
        end
        RUN: begin
          for (int c = 0; c < NCHUNK - 1; c++) begin
            if (idx == IDXW'(c + 1)) begin
              sum_q[c*CHUNK_W +: CHUNK_W] <= bus.add_sum;
            end
          end
          idx <= idx + 1'b1;
        end
        CAP: begin
          sum_q[(NCHUNK-1)*CHUNK_W +: CHUNK_W] <= bus.add_sum;
          cout_q <= bus.add_cout;
`ifdef KS_WIDE_SEQ_OVF_EN
          ovf_q  <= (op_a[W-1] == op_b[W-1]) && (bus.add_sum[CHUNK_W-1] != op_a[W-1]);
`endif
          idx    <= '0;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = cout_q;
`ifdef KS_WIDE_SEQ_OVF_EN
  assign bus.out_ovf   = ovf_q;
`endif
  assign bus.add_a     = add_a_c;
  assign bus.add_b     = add_b_c;
  assign bus.add_cin   = add_cin_c;

endmodule
